// File: rtl/bids22_pkg.sv
// Shared types and constants for the bids22 round logger.
package bids22_pkg;
  localparam int REC_W          = 42;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int CNT_W          = 5;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_X    = 2'b01,
    WIN_Y    = 2'b10,
    WIN_Z    = 2'b11
  } winner_e;

  typedef struct packed {
    logic [7:0]  round_id;
    winner_e     winner;
    logic [31:0] amount;
  } rec_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/bids22_round_logger_if.sv
// Auction-core / host bundle for the round logger; signal names match the core.
interface bids22_round_logger_if;
  import bids22_pkg::*;
  logic              X_win, Y_win, Z_win;
  logic              roundOver;
  logic [31:0]       maxBid;
  logic              clr;
  logic              rec_pop;
  logic              rec_valid;
  logic [REC_W-1:0]  rec_data;
  logic [CNT_W-1:0]  fifo_count;
  logic [15:0]       round_cnt;
  logic [7:0]        x_wins, y_wins, z_wins;
  logic [31:0]       revenue;
  logic              multi_win_err;
  logic              overflow;

  modport master (
    output X_win, Y_win, Z_win, roundOver, maxBid, clr, rec_pop,
    input  rec_valid, rec_data, fifo_count, round_cnt, x_wins, y_wins, z_wins,
           revenue, multi_win_err, overflow
  );
  modport slave (
    input  X_win, Y_win, Z_win, roundOver, maxBid, clr, rec_pop,
    output rec_valid, rec_data, fifo_count, round_cnt, x_wins, y_wins, z_wins,
           revenue, multi_win_err, overflow
  );
endinterface

// File: rtl/bids22_rec_fifo.sv
// Show-ahead record FIFO; clr beats push/pop, push into a full FIFO only lands with a pop.
module bids22_rec_fifo
  import bids22_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [REC_W-1:0] din,
  output logic [REC_W-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [REC_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [CNT_W-1:0] r_cnt;
  logic             w_pop, w_push;

  assign empty  = (r_cnt == '0);
  assign full   = (r_cnt == CNT_W'(DEPTH));
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);
  assign count  = r_cnt;
  // Head is gated so an empty FIFO presents all-zero data.
  assign dout   = empty ? '0 : r_mem[r_rd];

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (clr) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Storage needs no reset: reads are masked while empty.
  always_ff @(posedge clk) begin
    if (w_push && !clr) r_mem[r_wr] <= din;
  end
endmodule

// File: rtl/bids22_round_logger.sv
// Logs one record per roundOver rising edge and keeps running auction statistics.
module bids22_round_logger
  import bids22_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  bids22_round_logger_if.slave  bus
);
  logic             r_ro_prev;
  logic [15:0]      r_round_cnt;
  logic [7:0]       r_x_wins, r_y_wins, r_z_wins;
  logic [31:0]      r_revenue;
  logic             r_multi, r_ovf;

  logic             w_edge, w_single, w_multi, w_pop, w_drop, w_full, w_empty;
  logic [1:0]       w_nwin;
  winner_e          w_winner;
  logic [31:0]      w_amount;
  logic [32:0]      w_rev_sum;
  rec_t             w_rec;
  logic [REC_W-1:0] w_head;
  logic [CNT_W-1:0] w_count;

  assign w_edge    = bus.roundOver & ~r_ro_prev;
  assign w_nwin    = 2'(bus.X_win) + 2'(bus.Y_win) + 2'(bus.Z_win);
  assign w_single  = (w_nwin == 2'd1);
  assign w_multi   = (w_nwin >= 2'd2);
  assign w_amount  = w_single ? bus.maxBid : 32'd0;
  assign w_rev_sum = {1'b0, r_revenue} + {1'b0, w_amount};
  assign w_pop     = bus.rec_pop & ~w_empty;
  assign w_drop    = w_edge & w_full & ~w_pop;

  // Winner code only for a lone winner; ties and no-win both record NONE.
  always_comb begin
    w_winner = WIN_NONE;
    if (w_single) begin
      if (bus.X_win)      w_winner = WIN_X;
      else if (bus.Y_win) w_winner = WIN_Y;
      else                w_winner = WIN_Z;
    end
  end

  assign w_rec.round_id = r_round_cnt[7:0];
  assign w_rec.winner   = w_winner;
  assign w_rec.amount   = w_amount;

  bids22_rec_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .clr   (bus.clr),
    .push  (w_edge),
    .pop   (bus.rec_pop),
    .din   (w_rec),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // Edge detect and statistics; counters advance even when the record is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ro_prev   <= 1'b0;
      r_round_cnt <= '0;
      r_x_wins    <= '0;
      r_y_wins    <= '0;
      r_z_wins    <= '0;
      r_revenue   <= '0;
      r_multi     <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (bus.clr) begin
      r_ro_prev   <= 1'b0;
      r_round_cnt <= '0;
      r_x_wins    <= '0;
      r_y_wins    <= '0;
      r_z_wins    <= '0;
      r_revenue   <= '0;
      r_multi     <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_ro_prev <= bus.roundOver;
      if (w_edge) begin
        r_round_cnt <= r_round_cnt + 16'd1;
        if (w_multi)            r_multi  <= 1'b1;
        if (w_winner == WIN_X)  r_x_wins <= sat_inc8(r_x_wins);
        if (w_winner == WIN_Y)  r_y_wins <= sat_inc8(r_y_wins);
        if (w_winner == WIN_Z)  r_z_wins <= sat_inc8(r_z_wins);
        r_revenue <= w_rev_sum[32] ? 32'hFFFF_FFFF : w_rev_sum[31:0];
      end
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  assign bus.rec_valid     = ~w_empty;
  assign bus.rec_data      = w_head;
  assign bus.fifo_count    = w_count;
  assign bus.round_cnt     = r_round_cnt;
  assign bus.x_wins        = r_x_wins;
  assign bus.y_wins        = r_y_wins;
  assign bus.z_wins        = r_z_wins;
  assign bus.revenue       = r_revenue;
  assign bus.multi_win_err = r_multi;
  assign bus.overflow      = r_ovf;
endmodule

// File: tb/tb_bids22_round_logger.sv
// Scoreboard bench: a queue-based reference model predicts records and statistics.
module tb_bids22_round_logger;
  import bids22_pkg::*;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bids22_round_logger_if bus();

  bids22_round_logger #(.FIFO_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [41:0] exp_q[$];
  logic        m_prev, m_mult, m_ovf;
  logic [15:0] m_rounds;
  int          m_x, m_y, m_z;
  longint      m_rev;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_clear();
    exp_q.delete();
    m_prev = 1'b0; m_mult = 1'b0; m_ovf = 1'b0;
    m_rounds = '0; m_x = 0; m_y = 0; m_z = 0; m_rev = 0;
  endfunction

  function automatic void m_step();
    int nw;
    logic [1:0] w;
    logic [31:0] amt;
    if (bus.roundOver && !m_prev) begin
      nw = int'(bus.X_win) + int'(bus.Y_win) + int'(bus.Z_win);
      w = 2'd0; amt = 32'd0;
      if (nw == 1) begin
        amt = bus.maxBid;
        w = bus.X_win ? 2'd1 : (bus.Y_win ? 2'd2 : 2'd3);
      end
      if (nw >= 2) m_mult = 1'b1;
      if (exp_q.size() < DEPTH) exp_q.push_back({m_rounds[7:0], w, amt});
      else m_ovf = 1'b1;
      m_rounds = m_rounds + 16'd1;
      if (w == 2'd1 && m_x < 255) m_x++;
      if (w == 2'd2 && m_y < 255) m_y++;
      if (w == 2'd3 && m_z < 255) m_z++;
      m_rev = m_rev + longint'(amt);
      if (m_rev > 64'hFFFF_FFFF) m_rev = 64'hFFFF_FFFF;
    end
    m_prev = bus.roundOver;
  endfunction

  task automatic compare_all();
    chk("rec_valid", 64'(bus.rec_valid), 64'(exp_q.size() > 0));
    chk("rec_data", 64'(bus.rec_data), (exp_q.size() > 0) ? 64'(exp_q[0]) : 64'd0);
    chk("fifo_count", 64'(bus.fifo_count), 64'(exp_q.size()));
    chk("round_cnt", 64'(bus.round_cnt), 64'(m_rounds));
    chk("x_wins", 64'(bus.x_wins), 64'(m_x));
    chk("y_wins", 64'(bus.y_wins), 64'(m_y));
    chk("z_wins", 64'(bus.z_wins), 64'(m_z));
    chk("revenue", 64'(bus.revenue), 64'(m_rev));
    chk("multi_win_err", 64'(bus.multi_win_err), 64'(m_mult));
    chk("overflow", 64'(bus.overflow), 64'(m_ovf));
  endtask

  // Model advances with every DUT clock edge / async reset.
  initial begin
    m_clear();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n || bus.clr) m_clear();
      else m_step();
    end
  end

  // Monitor: compare on the falling edge, retire head when the host pops it.
  initial begin
    forever begin
      @(negedge clk);
      compare_all();
      if (reset_n && bus.rec_pop && exp_q.size() > 0) void'(exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic round(input logic x, input logic y, input logic z, input logic [31:0] bid);
    bus.X_win = x; bus.Y_win = y; bus.Z_win = z; bus.maxBid = bid; bus.roundOver = 1'b1;
    tick();
    bus.X_win = 1'b0; bus.Y_win = 1'b0; bus.Z_win = 1'b0; bus.maxBid = '0; bus.roundOver = 1'b0;
  endtask

  task automatic do_clr();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    tick();
  endtask

  logic [15:0] rc_save;

  initial begin
    bus.X_win = 1'b0; bus.Y_win = 1'b0; bus.Z_win = 1'b0; bus.roundOver = 1'b0;
    bus.maxBid = '0; bus.clr = 1'b0; bus.rec_pop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    reset_n = 1'b1;
    tick();

    // Single Y win
    round(1'b0, 1'b1, 1'b0, 32'h64);
    chk("single_rec", 64'(bus.rec_data), 64'({8'h00, 2'b10, 32'h64}));
    chk("single_y", 64'(bus.y_wins), 64'd1);
    chk("single_rev", 64'(bus.revenue), 64'h64);
    chk("single_rc", 64'(bus.round_cnt), 64'd1);
    tick();
    do_clr();

    // Tie between X and Z
    round(1'b1, 1'b0, 1'b1, 32'h50);
    chk("tie_rec", 64'(bus.rec_data), 64'({8'h00, 2'b00, 32'h0}));
    chk("tie_err", 64'(bus.multi_win_err), 64'd1);
    chk("tie_xz", 64'({bus.x_wins, bus.z_wins}), 64'd0);
    chk("tie_rev", 64'(bus.revenue), 64'd0);
    tick();
    do_clr();

    // Five rounds into a depth-4 FIFO
    for (int i = 0; i < 5; i++) begin
      round(1'b1, 1'b0, 1'b0, 32'(i + 1));
      tick();
    end
    chk("ovf_count", 64'(bus.fifo_count), 64'd4);
    chk("ovf_flag", 64'(bus.overflow), 64'd1);
    chk("ovf_rc", 64'(bus.round_cnt), 64'd5);
    chk("ovf_head", 64'(bus.rec_data[41:34]), 64'd0);
    do_clr();

    // Full FIFO, pop together with a new round
    for (int i = 0; i < 4; i++) begin
      round(1'b0, 1'b0, 1'b1, 32'h10);
      tick();
    end
    bus.rec_pop = 1'b1;
    round(1'b0, 1'b1, 1'b0, 32'h20);
    bus.rec_pop = 1'b0;
    chk("pp_count", 64'(bus.fifo_count), 64'd4);
    chk("pp_ovf", 64'(bus.overflow), 64'd0);
    chk("pp_head", 64'(bus.rec_data[41:34]), 64'd1);
    tick();
    do_clr();

    // Revenue saturation and held roundOver
    bus.rec_pop = 1'b1;
    round(1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0);
    tick();
    round(1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0);
    tick();
    chk("rev_sat", 64'(bus.revenue), 64'hFFFF_FFFF);
    rc_save = bus.round_cnt;
    bus.roundOver = 1'b1;
    repeat (10) tick();
    bus.roundOver = 1'b0;
    tick();
    chk("held_once", 64'(bus.round_cnt), 64'(rc_save + 16'd1));
    bus.rec_pop = 1'b0;
    do_clr();

    // Asynchronous reset with three queued records
    for (int i = 0; i < 3; i++) begin
      round(1'b0, 1'b1, 1'b0, 32'h7);
      tick();
    end
    #2 reset_n = 1'b0;
    #1;
    chk("rst_valid", 64'(bus.rec_valid), 64'd0);
    chk("rst_all", 64'({bus.fifo_count, bus.round_cnt, bus.y_wins, bus.revenue}), 64'd0);
    compare_all();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) tick();
    chk("rst_idle", 64'(bus.rec_valid), 64'd0);

    // roundOver already high when reset releases: one round only
    #2 reset_n = 1'b0;
    bus.roundOver = 1'b1; bus.Z_win = 1'b1; bus.maxBid = 32'h33;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) tick();
    chk("rel_rc", 64'(bus.round_cnt), 64'd1);
    chk("rel_z", 64'(bus.z_wins), 64'd1);
    bus.roundOver = 1'b0; bus.Z_win = 1'b0; bus.maxBid = '0;
    tick();
    do_clr();

    // Win counter saturation
    bus.rec_pop = 1'b1;
    for (int i = 0; i < 258; i++) begin
      round(1'b1, 1'b0, 1'b0, 32'h1);
      tick();
    end
    chk("x_sat", 64'(bus.x_wins), 64'hFF);
    bus.rec_pop = 1'b0;
    do_clr();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bus.roundOver = ($urandom_range(0, 2) == 0);
      bus.X_win     = $urandom_range(0, 2) == 0;
      bus.Y_win     = $urandom_range(0, 2) == 0;
      bus.Z_win     = $urandom_range(0, 2) == 0;
      bus.maxBid    = ($urandom_range(0, 3) == 0) ? (32'hF000_0000 | 32'($urandom)) : 32'($urandom_range(0, 1000));
      bus.rec_pop   = ($urandom_range(0, 2) == 0);
      bus.clr       = ($urandom_range(0, 59) == 0);
      tick();
    end
    bus.roundOver = 1'b0; bus.X_win = 1'b0; bus.Y_win = 1'b0; bus.Z_win = 1'b0;
    bus.rec_pop = 1'b0; bus.clr = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bids22_round_logger.md
BIDS22_ROUND_LOGGER -- requirements
Module: bids22_round_logger

Interface
REQ-001 SHALL have parameter: FIFO_DEPTH, 4, record FIFO entries (power of 2, 2..16).
REQ-002 SHALL have ports:
- clk  in  1  single clock, all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- X_win, Y_win, Z_win  in  1 each  auction core win outputs.
- roundOver  in  1  auction core round-complete indication.
- maxBid  in  32  auction core winning amount.
- clr  in  1  synchronous clear of all state.
- rec_pop  in  1  host consumes head record.
- rec_valid  out  1  FIFO non-empty.
- rec_data  out  42  head record: [41:34] round id, [33:32] winner code, [31:0] amount.
- fifo_count  out  5  current occupancy.
- round_cnt  out  16  rounds logged.
- x_wins, y_wins, z_wins  out  8 each  per-bidder win counts.
- revenue  out  32  sum of winning amounts.
- multi_win_err  out  1  sticky.
- overflow  out  1  sticky.

Function
REQ-003 SHALL detect a round on the rising edge of roundOver (roundOver=1 and registered previous value 0); a held-high roundOver SHALL log once only.
REQ-004 SHALL sample X_win/Y_win/Z_win and maxBid in the same cycle as the detected edge.
REQ-005 SHALL encode winner: 00 none, 01 X, 10 Y, 11 Z; amount = maxBid if exactly one win set, else 0.
REQ-006 SHALL, when two or more wins are set, record winner 00, amount 0, set multi_win_err, and leave win counters and revenue unchanged.
REQ-007 SHALL use round_cnt[7:0] before increment as the record round id.
REQ-008 SHALL increment round_cnt once per detected round, wrapping 0xFFFF->0.
REQ-009 SHALL increment the matching per-bidder win count on a single-winner round, saturating at 0xFF.
REQ-010 SHALL add amount to revenue, saturating at 0xFFFF_FFFF (33-bit internal sum).
REQ-011 SHALL make a captured record visible at rec_valid/rec_data one cycle after the edge cycle, and counters likewise.
REQ-012 SHALL use show-ahead FIFO: rec_data = head whenever rec_valid=1; rec_pop with rec_valid=1 removes head next edge; rec_pop with rec_valid=0 SHALL be ignored.
REQ-013 SHALL, with FIFO full and a new round, drop the record, set overflow, and still update counters.
REQ-014 SHALL, with FIFO full and push plus pop in the same cycle, accept the push (count stays FIFO_DEPTH, no overflow).
REQ-015 SHALL, with FIFO empty, take no pass-through; a push in an empty cycle shows rec_valid next cycle.
REQ-016 SHALL give clr priority over capture and pop in the same cycle: all state returns to reset values, the coincident round is discarded.

Reset
REQ-017 SHALL, on reset_n=0, asynchronously drive: rec_valid 0, rec_data 0, fifo_count 0, round_cnt 0, x_wins/y_wins/z_wins 0, revenue 0, multi_win_err 0, overflow 0, previous-roundOver register 0.
REQ-018 SHALL discard in-flight capture on reset mid-operation; after release, a roundOver already high SHALL log one round on the first cycle.

Structure
REQ-019 SHALL place winner code enum, record struct (round id, winner, amount), REC_W=42 and default FIFO_DEPTH in shared package bids22_pkg.
REQ-020 SHALL implement the record store as sub-module bids22_rec_fifo (show-ahead, push/pop/clr, count, full/empty).
REQ-021 SHALL connect to the auction core through the existing bids22 interface signals without renaming them.

Verification
REQ-022 SHALL cover: single round, Y_win=1, maxBid=0x64 -> next cycle rec_data={0x00,10,0x64}, y_wins=1, revenue=0x64, round_cnt=1.
REQ-023 SHALL cover: X_win=Z_win=1, maxBid=0x50 -> record winner 00, amount 0, multi_win_err=1, x_wins=z_wins=0, revenue unchanged.
REQ-024 SHALL cover: 5 rounds without pop (depth 4) -> fifo_count=4, overflow=1, round_cnt=5, head round id 0.
REQ-025 SHALL cover: full FIFO, rec_pop with a new round edge -> fifo_count stays 4, overflow stays 0, head becomes round id 1.
REQ-026 SHALL cover: revenue preset near max via rounds of maxBid=0xFFFF_FFF0 twice -> revenue=0xFFFF_FFFF; roundOver held 10 cycles -> round_cnt +1 only.
REQ-027 SHALL cover: reset_n pulsed low mid-stream with 3 queued records -> all outputs 0 immediately, no records after release unless a new edge.
